// File: rtl/encoder_8to3_pending_pkg.sv
// Shared constants, FSM encoding and the code-to-one-hot helper for the
// pending-request priority encoder.
package encoder_8to3_pending_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } state_t;

   // Same mapping as the 3-to-8 decoder: code n sets bit n.
   function automatic logic [N_REQ-1:0] onehot3to8(input logic [IDX_W-1:0] code);
      logic [N_REQ-1:0] v;
      v = '0;
      v[code] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/encoder_8to3_pending_prio_enc_8to3.sv
// Combinational 8-to-3 priority encoder; the highest set index wins.
module prio_enc_8to3
   import encoder_8to3_pending_pkg::*;
(
   input  logic [N_REQ-1:0] i_vec,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   always_comb begin
      o_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (i_vec[i]) o_idx = i[IDX_W-1:0];
      end
   end

   assign o_any = |i_vec;

endmodule

// File: rtl/encoder_8to3_pending.sv
// Registered 8-to-3 priority encoder with pending-request capture and a
// valid/ack handshake toward the dispatch logic.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | nothing presented, valid=0, code=0
// ST_PRESENT | valid=1, code held stable until acked
module encoder_8to3_pending
   import encoder_8to3_pending_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   input  logic             ack,
   output logic             valid,
   output logic [IDX_W-1:0] code,
   output logic [N_REQ-1:0] pending,
   output logic             dup
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDX_W-1:0] r_code;
   logic [IDX_W-1:0] w_code_nxt;
   logic [N_REQ-1:0] r_pending;
   logic             r_dup;

   logic [N_REQ-1:0] w_req_g;
   logic [N_REQ-1:0] w_clr;
   logic [N_REQ-1:0] w_pend_nxt;
   logic [IDX_W-1:0] w_prio_idx;
   logic             w_prio_any;
   logic             w_valid;

   assign w_valid    = (r_state == ST_PRESENT);
   assign w_req_g    = en ? req : '0;
   assign w_clr      = (w_valid && ack) ? onehot3to8(r_code) : '0;
   // Set wins over clear so a same-cycle re-request re-pends as a new event.
   assign w_pend_nxt = (r_pending & ~w_clr) | w_req_g;

   prio_enc_8to3 u_prio (
      .i_vec (w_pend_nxt),
      .o_idx (w_prio_idx),
      .o_any (w_prio_any)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_code_nxt  = r_code;
      case (r_state)
         ST_IDLE: begin
            w_code_nxt = '0;
            if (w_prio_any) begin
               w_state_nxt = ST_PRESENT;
               w_code_nxt  = w_prio_idx;
            end
         end
         ST_PRESENT: begin
            if (ack) begin
               if (w_prio_any) begin
                  w_code_nxt = w_prio_idx;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_code_nxt  = '0;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_code_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_code    <= '0;
         r_pending <= '0;
         r_dup     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_code    <= w_code_nxt;
         r_pending <= w_pend_nxt;
         r_dup     <= |(w_req_g & r_pending & ~w_clr);
      end
   end

   assign valid   = w_valid;
   assign code    = r_code;
   assign pending = r_pending;
   assign dup     = r_dup;

endmodule

// File: doc/encoder_8to3_pending.md
Name: encoder_8to3_pending

Overview:
- Registered 8-to-3 priority encoder with pending-request capture. It is the encode-side counterpart to the team's 3-to-8 one-hot decoder.
- Latches eight request lines into a pending register and presents the highest-index pending request as a 3-bit code with a valid/ack handshake.
- Clears each request once it has been consumed.
- Sits in front of interrupt/event dispatch logic, which consumes one code per ack.

Parameters:
N_REQ, 8, number of request lines (fixed at 8; parameter for readability only)
IDX_W, 3, code width, equals log2(N_REQ)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  capture enable; when 0, req is ignored
req  input  8  request lines, sampled every clk edge; a high bit sets the matching pending bit
ack  input  1  consumer accepts the presented code; meaningful only while valid=1
valid  output  1  code holds a pending request
code  output 3  index of presented request; 0 when valid=0
pending  output  8  current pending register (status)
dup  output  1  one-cycle pulse: a req bit arrived whose pending bit was already set

Behaviour:
- Reset (rst_n=0, asynchronous): pending=8'h00, valid=0, code=3'd0, dup=0, FSM=IDLE. Reset asserted mid-handshake discards all pending requests. The first cycle after release behaves as IDLE with empty pending.
- Definitions, all evaluated combinationally each cycle:
  - req_g = en ? req : 8'h00
  - clr = (valid && ack) ? onehot(code) : 8'h00
  - pend_nxt = (pending & ~clr) | req_g
- The set term has priority over the clear term. A req on the bit being acked in the same cycle re-pends that bit as a new event.
- pending <= pend_nxt on every clock edge.
- FSM states:
  - IDLE (valid=0).
  - PRESENT (valid=1, code held stable).
- IDLE transitions:
  - If pend_nxt != 0: code <= prio(pend_nxt), valid <= 1, go to PRESENT.
  - Otherwise stay in IDLE with code=0.
- PRESENT transitions:
  - ack=0: hold code and valid. A newly arrived higher-priority request must NOT change code while it is unacknowledged.
  - ack=1 and pend_nxt != 0: load code <= prio(pend_nxt) and stay in PRESENT. This is back-to-back with no bubble.
  - ack=1 and pend_nxt == 0: valid <= 0, code <= 0, go to IDLE.
- prio(): highest set index wins (bit 7 highest, bit 0 lowest).
- Latency: req high in cycle t with FSM idle gives valid=1 with the code in cycle t+1.
- Throughput: one code per cycle while ack is held high and requests remain pending.
- dup <= |(req_g & pending & ~clr), registered, so it is a single-cycle pulse per occurrence. The duplicate request is merged: there is no count, so the event is lost except for the dup pulse.
- en=0:
  - req is ignored entirely (no capture, no dup).
  - The pending register, the presented code, and the ack handshake continue to operate normally. Pending requests drain under en=0.
- ack while valid=0 is ignored (clr=0).
- All outputs are registered. There are no combinational input-to-output paths.

Decomposition:
- Shared package/include holds:
  - Constants N_REQ=8 and IDX_W=3.
  - FSM state encoding: IDLE=1'b0, PRESENT=1'b1.
  - A onehot3to8 function, reusing the decoder mapping (code n sets bit n).
- One natural combinational sub-module: prio_enc_8to3. Input: 8-bit vector. Outputs: 3-bit index and an any-set flag.
- Top level holds the pending register, FSM, clear/set logic, and dup register.

Test Plan:
1. Reset and single request:
   - Release rst_n, en=1, req=8'h10 for one cycle.
   - Next cycle: valid=1, code=4, pending=8'h10.
   - ack=1 for one cycle, then valid=0, code=0, pending=8'h00.
2. Priority and hold:
   - req=8'h05 in cycle t gives code=2 at t+1.
   - With ack=0, pulse req=8'h80 at t+2: code stays 2, pending=8'h85.
   - ack at t+3 gives code=7 at t+4.
   - ack at t+4 gives code=0 with valid=1 at t+5.
   - ack at t+5 gives valid=0.
3. Back-to-back drain:
   - Pend 8'hFF, then hold ack=1.
   - Codes 7,6,5,4,3,2,1,0 on consecutive cycles, then valid=0, with no bubble cycles.
4. Simultaneous set and clear:
   - While code=3 is presented, drive ack=1 and req=8'h08 in the same cycle.
   - Next cycle: pending[3]=1, valid=1, code=3, dup=0.
5. Duplicate and enable:
   - With pending=8'h02 and ack=0, req=8'h02 gives dup=1 for exactly one cycle and pending unchanged.
   - With en=0, req=8'hFF leaves pending unchanged and dup=0.
6. Asynchronous reset mid-operation:
   - With pending=8'hA0 and valid=1, assert rst_n=0 between clock edges.
   - Outputs clear immediately without a clock edge: valid=0, code=0, pending=0, dup=0.
   - No stale code appears after release.
